pipelined_adder: RTL

//  Parametrised, pipelined ripple-carry adder: WIDTH-bit a + b + cin -> sum, cout.

---
 rtl/pipelined_adder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder
//  Brief    : Pipelined ripple-carry adder with valid/ready handshakes.
//             Optional macro OVERFLOW_DETECT_EN adds a registered signed
//             overflow flag on ovf (tied low otherwise).
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_adder #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = WIDTH / STAGES;

   if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("pipelined_adder: WIDTH must be >= 1 and a multiple of STAGES");
   end

   logic advance;

   // Reset forces advance so in_ready is high while rst is asserted.
   assign advance  = rst | ~out_valid | out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int IN_W = WIDTH - k * CW;
      localparam int REM  = IN_W - CW;

      logic [IN_W-1:0]       a_in;
      logic [IN_W-1:0]       b_in;
      logic                  c_in;
      logic                  v_in;
      logic [CW:0]           chunk;
      logic [(k+1)*CW-1:0]   s_next;
      logic                  valid_q;
      logic                  carry_q;
      logic [(k+1)*CW-1:0]   sum_q;

      assign chunk = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

      if (k == 0) begin : g_first
         assign a_in   = a;
         assign b_in   = b;
         assign c_in   = cin;
         assign v_in   = in_valid;
         assign s_next = chunk[CW-1:0];
      end else begin : g_next
         assign a_in   = g_stage[k-1].g_ops.a_q;
         assign b_in   = g_stage[k-1].g_ops.b_q;
         assign c_in   = g_stage[k-1].carry_q;
         assign v_in   = g_stage[k-1].valid_q;
         assign s_next = {chunk[CW-1:0], g_stage[k-1].sum_q};
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
         end else if (advance) begin
            valid_q <= v_in;
            carry_q <= chunk[CW];
            sum_q   <= s_next;
         end
      end

      // Operand bits for later chunks travel with their stage (input skew).
      if (REM > 0) begin : g_ops
         logic [REM-1:0] a_q;
         logic [REM-1:0] b_q;

         always_ff @(posedge clk) begin
            if (advance) begin
               a_q <= a_in[IN_W-1:CW];
               b_q <= b_in[IN_W-1:CW];
            end
         end
      end

`ifdef OVERFLOW_DETECT_EN
      if (k == STAGES - 1) begin : g_ovf
         logic ovf_q;

         // a^b^sum at the MSB recovers the carry into the MSB.
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (advance) begin
               ovf_q <= a_in[CW-1] ^ b_in[CW-1] ^ chunk[CW-1] ^ chunk[CW];
            end
         end
      end
`endif
   end

   assign out_valid = g_stage[STAGES-1].valid_q;
   assign sum       = g_stage[STAGES-1].sum_q;
   assign cout      = g_stage[STAGES-1].carry_q;

`ifdef OVERFLOW_DETECT_EN
   assign ovf = g_stage[STAGES-1].g_ovf.ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire
